gpio_ctrl_gen2: RTL

Parametrised second-generation GPIO register block, single clock domain. Pads are synchronised and optionally debounced per bit, then sampled into RGPIO_IN.
Adds the following over the first-generation block:
- atomic OUT set/clear
- write-1-to-clear interrupt status
- per-bit edge/level and both-edge trigger modes
- registered interrupt output

Sits behind the APB slave interface, which drives the addr/we/data strobes; drives pad and interrupt-controller signals.

---
 rtl/gpio_ctrl_gen2.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gpio_ctrl_gen2.sv
// gpio_ctrl_gen2: parametrised GPIO register block with synchronised, optionally debounced inputs and interrupts
//   sys_clk, sys_rst (async, active-low)        clock and reset
//   gpio_addr, gpio_we, gpio_dat_i, gpio_dat_o  register bus from the APB slave; read data lags the address by one cycle
//   in_pad_i                                    asynchronous pad inputs
//   aux_i                                       alternate output sources, selected per bit by AUX
//   out_pad_o, oen_padoe_o                      pad outputs and output enables
//   gpio_inta_o                                 registered interrupt request
//   Macro GPIO_DEBOUNCE_EN adds per-bit debounce (DBEN/DBCNT); without it, those registers read 0.
module gpio_ctrl_gen2 #(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       gpio_addr,
    input  logic              gpio_we,
    input  logic [31:0]       gpio_dat_i,
    output logic [31:0]       gpio_dat_o,
    input  logic [GPIO_W-1:0] in_pad_i,
    input  logic [GPIO_W-1:0] aux_i,
    output logic [GPIO_W-1:0] out_pad_o,
    output logic [GPIO_W-1:0] oen_padoe_o,
    output logic              gpio_inta_o
);
    localparam logic [31:0] A_IN    = 32'h00;
    localparam logic [31:0] A_OUT   = 32'h04;
    localparam logic [31:0] A_OE    = 32'h08;
    localparam logic [31:0] A_INTE  = 32'h0C;
    localparam logic [31:0] A_PTRIG = 32'h10;
    localparam logic [31:0] A_AUX   = 32'h14;
    localparam logic [31:0] A_CTRL  = 32'h18;
    localparam logic [31:0] A_INTS  = 32'h1C;
    localparam logic [31:0] A_SET   = 32'h20;
    localparam logic [31:0] A_CLR   = 32'h24;
    localparam logic [31:0] A_IMODE = 32'h28;
    localparam logic [31:0] A_BOTH  = 32'h2C;
    localparam logic [31:0] A_DBEN  = 32'h30;
    localparam logic [31:0] A_DBCNT = 32'h34;

    logic [GPIO_W-1:0] out_q, oe_q, inte_q, ptrig_q, aux_q, ints_q, imode_q, both_q;
    logic [GPIO_W-1:0] filt, in_d, s, wd, rise, fall, ev, w1c;
    logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
    logic        ctrl_inte;
    logic [31:0] rd, rd_dben, rd_dbcnt;

    function automatic logic wr_hit(input logic we, input logic [31:0] addr, input logic [31:0] a);
        return we && addr == a;
    endfunction

    function automatic logic [31:0] zx(input logic [GPIO_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_W-1:0] = v;
        return r;
    endfunction

    assign wd          = gpio_dat_i[GPIO_W-1:0];
    assign s           = sync_q[SYNC_STAGES-1];
    assign rise        = filt & ~in_d;
    assign fall        = ~filt & in_d;
    // level: match PTRIG polarity; edge: BOTH takes any edge, otherwise PTRIG picks the direction
    assign ev          = (imode_q & ~(filt ^ ptrig_q))
                       | (~imode_q & both_q & (rise | fall))
                       | (~imode_q & ~both_q & ((ptrig_q & rise) | (~ptrig_q & fall)));
    assign w1c         = wr_hit(gpio_we, gpio_addr, A_INTS) ? wd : '0;
    assign out_pad_o   = (out_q & ~aux_q) | (aux_i & aux_q);
    assign oen_padoe_o = oe_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            aux_q       <= '0;
            imode_q     <= '0;
            both_q      <= '0;
            ctrl_inte   <= 1'b0;
            ints_q      <= '0;
            in_d        <= '0;
            sync_q      <= '0;
            gpio_inta_o <= 1'b0;
            gpio_dat_o  <= '0;
        end else begin
            if (wr_hit(gpio_we, gpio_addr, A_OUT)) out_q <= wd;
            else if (wr_hit(gpio_we, gpio_addr, A_SET)) out_q <= out_q | wd;
            else if (wr_hit(gpio_we, gpio_addr, A_CLR)) out_q <= out_q & ~wd;
            if (wr_hit(gpio_we, gpio_addr, A_OE)) oe_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_INTE)) inte_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_PTRIG)) ptrig_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_AUX)) aux_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_IMODE)) imode_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_BOTH)) both_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_CTRL)) ctrl_inte <= gpio_dat_i[0];
            sync_q      <= {sync_q[SYNC_STAGES-2:0], in_pad_i};
            in_d        <= filt;
            // a fresh event is OR-ed in after the clear, so it wins over a same-cycle W1C
            ints_q      <= (ints_q & ~w1c) | (ev & inte_q & {GPIO_W{ctrl_inte}});
            gpio_inta_o <= ctrl_inte & |ints_q;
            gpio_dat_o  <= rd;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [GPIO_W-1:0]                dben_q;
    logic [DB_CNT_W-1:0]              dbcnt_q;
    logic [GPIO_W-1:0][DB_CNT_W-1:0]  cnt;

    // filt follows s once it has disagreed for DBCNT+1 consecutive cycles; disabled bits pass straight through
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dben_q  <= '0;
            dbcnt_q <= '0;
            cnt     <= '0;
            filt    <= '0;
        end else begin
            if (wr_hit(gpio_we, gpio_addr, A_DBEN)) dben_q <= wd;
            if (wr_hit(gpio_we, gpio_addr, A_DBCNT)) dbcnt_q <= gpio_dat_i[DB_CNT_W-1:0];
            for (int i = 0; i < GPIO_W; i++) begin
                filt[i] <= (!dben_q[i] || cnt[i] == dbcnt_q) ? s[i] : filt[i];
                cnt[i]  <= (!dben_q[i] || s[i] == filt[i] || cnt[i] == dbcnt_q) ? '0 : cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_dbcnt = '0;
        rd_dbcnt[DB_CNT_W-1:0] = dbcnt_q;
    end
    assign rd_dben = zx(dben_q);
`else
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) filt <= '0;
        else filt <= s;
    end

    assign rd_dben  = '0;
    assign rd_dbcnt = '0;
`endif

    always_comb begin
        case (gpio_addr)
            A_IN:    rd = zx(filt);
            A_OUT:   rd = zx(out_q);
            A_OE:    rd = zx(oe_q);
            A_INTE:  rd = zx(inte_q);
            A_PTRIG: rd = zx(ptrig_q);
            A_AUX:   rd = zx(aux_q);
            A_CTRL:  rd = {30'b0, |ints_q, ctrl_inte};
            A_INTS:  rd = zx(ints_q);
            A_IMODE: rd = zx(imode_q);
            A_BOTH:  rd = zx(both_q);
            A_DBEN:  rd = rd_dben;
            A_DBCNT: rd = rd_dbcnt;
            default: rd = '0;
        endcase
    end
endmodule
